write_back_stage: RTL and testbench

// - Final (WB) stage of the 5-stage RV32I_Zicsr pipeline: holds the MEM/WB pipeline register, selects the

---
 rtl/write_back_stage_pkg.sv | 20 ++
 rtl/write_back_stage_load_align.sv | 38 +++
 rtl/write_back_stage.sv | 88 ++++++++
 tb/tb_write_back_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/write_back_stage_pkg.sv
// rtl/write_back_stage_pkg.sv - shared encodings for the WB stage
package write_back_stage_pkg;

    localparam int XLEN      = 32;
    localparam int INSTRET_W = 64;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_CSR  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/write_back_stage_load_align.sv
// rtl/write_back_stage_load_align.sv - byte/half select and extension of load data
module write_back_stage_load_align
    import write_back_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (offset)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
    end

    // offset[0] is ignored for halfwords: misaligned accesses trap before WB
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (funct3)
            FUNCT3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            FUNCT3_LH:  data = {{16{sel_half[15]}}, sel_half};
            FUNCT3_LBU: data = {24'h000000, sel_byte};
            FUNCT3_LHU: data = {16'h0000, sel_half};
            default:    data = word;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - MEM/WB register, result select, register-file write and instret
module write_back_stage
    import write_back_stage_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_flush,
    input  logic                 i_rd_we,
    input  logic [4:0]           i_rd_addr,
    input  logic [1:0]           i_wb_sel,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic [XLEN-1:0]      i_load_data,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [XLEN-1:0]      i_csr_rdata,
    output logic                 o_rd_we,
    output logic [4:0]           o_rd_addr,
    output logic [XLEN-1:0]      o_rd_data,
    output logic                 o_retire,
    output logic [INSTRET_W-1:0] o_instret
);

    logic                 r_valid;
    logic                 r_rd_we;
    logic [4:0]           r_rd_addr;
    wb_sel_e              r_wb_sel;
    logic [2:0]           r_funct3;
    logic [XLEN-1:0]      r_alu_result;
    logic [XLEN-1:0]      r_load_data;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_csr_rdata;
    logic [INSTRET_W-1:0] instret_q;
    logic [XLEN-1:0]      load_value;

    // WB never stalls: the register reloads every edge; a flush turns the slot into a bubble
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_rd_we      <= 1'b0;
            r_rd_addr    <= 5'd0;
            r_wb_sel     <= WB_SEL_ALU;
            r_funct3     <= 3'd0;
            r_alu_result <= '0;
            r_load_data  <= '0;
            r_pc         <= '0;
            r_csr_rdata  <= '0;
            instret_q    <= '0;
        end else begin
            r_valid      <= i_valid & ~i_flush;
            r_rd_we      <= i_rd_we;
            r_rd_addr    <= i_rd_addr;
            r_wb_sel     <= wb_sel_e'(i_wb_sel);
            r_funct3     <= i_funct3;
            r_alu_result <= i_alu_result;
            r_load_data  <= i_load_data;
            r_pc         <= i_pc;
            r_csr_rdata  <= i_csr_rdata;
            if (r_valid) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    write_back_stage_load_align u_load_align (
        .funct3 (r_funct3),
        .offset (r_alu_result[1:0]),
        .word   (r_load_data),
        .data   (load_value)
    );

    always_comb begin
        o_rd_data = r_alu_result;
        case (r_wb_sel)
            WB_SEL_ALU:  o_rd_data = r_alu_result;
            WB_SEL_LOAD: o_rd_data = load_value;
            WB_SEL_PC4:  o_rd_data = r_pc + 32'd4;
            WB_SEL_CSR:  o_rd_data = r_csr_rdata;
            default:     o_rd_data = r_alu_result;
        endcase
    end

    assign o_rd_we   = r_valid & r_rd_we & (r_rd_addr != 5'd0);
    assign o_rd_addr = r_rd_addr;
    assign o_retire  = r_valid;
    assign o_instret = instret_q;

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - randomized and directed self-checking bench for write_back_stage
module tb_write_back_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_rd_we = 1'b0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic [1:0]  i_wb_sel = 2'd0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_alu_result = 32'd0;
    logic [31:0] i_load_data = 32'd0;
    logic [31:0] i_pc = 32'd0;
    logic [31:0] i_csr_rdata = 32'd0;
    logic        o_rd_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_retire;
    logic [63:0] o_instret;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: the instruction currently held in WB and the retire count
    logic        m_valid, m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_result;
    logic [63:0] m_instret;

    always #5 i_clk = ~i_clk;

    write_back_stage dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_flush      (i_flush),
        .i_rd_we      (i_rd_we),
        .i_rd_addr    (i_rd_addr),
        .i_wb_sel     (i_wb_sel),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_load_data  (i_load_data),
        .i_pc         (i_pc),
        .i_csr_rdata  (i_csr_rdata),
        .o_rd_we      (o_rd_we),
        .o_rd_addr    (o_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_retire     (o_retire),
        .o_instret    (o_instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(off)));
        h = 16'(w >> (16 * int'(off[1])));
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        case (i_wb_sel)
            2'b00:   return i_alu_result;
            2'b01:   return ref_load(i_funct3, i_alu_result[1:0], i_load_data);
            2'b10:   return i_pc + 32'd4;
            default: return i_csr_rdata;
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".we"},      64'(o_rd_we),   64'(m_valid && m_we && m_rd != 0));
        check({tag, ".addr"},    64'(o_rd_addr), 64'(m_rd));
        check({tag, ".data"},    64'(o_rd_data), 64'(m_result));
        check({tag, ".retire"},  64'(o_retire),  64'(m_valid));
        check({tag, ".instret"}, o_instret,      m_instret);
    endtask

    // one clock edge: model captures the applied inputs, then outputs are compared 1 ns later
    task automatic step(input string tag);
        @(posedge i_clk);
        if (m_valid) m_instret = m_instret + 64'd1;
        m_valid  = i_valid && !i_flush;
        m_we     = i_rd_we;
        m_rd     = i_rd_addr;
        m_result = ref_result();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic v, input logic f, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] csr);
        i_valid = v; i_flush = f; i_rd_we = we; i_rd_addr = rd; i_wb_sel = sel;
        i_funct3 = f3; i_alu_result = alu; i_load_data = ld; i_pc = pc; i_csr_rdata = csr;
    endtask

    task automatic do_reset();
        drive(1, 0, 1, 5'd5, 2'b00, 3'b000, 32'hAAAA_5555, 32'h0, 32'h0, 32'h0);
        i_rst = 1'b1;
        #1;
        check("rst.we", 64'(o_rd_we), 64'd0);
        check("rst.retire", 64'(o_retire), 64'd0);
        check("rst.instret", o_instret, 64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_hold.we", 64'(o_rd_we), 64'd0);
        check("rst_hold.data", 64'(o_rd_data), 64'd0);
        check("rst_hold.instret", o_instret, 64'd0);
        m_valid = 0; m_we = 0; m_rd = 0; m_result = 0; m_instret = 0;
        i_rst = 1'b0;
    endtask

    initial begin
        m_valid = 0; m_we = 0; m_rd = 0; m_result = 0; m_instret = 0;
        do_reset();

        drive(1, 0, 1, 5'd5, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 32'h0);
        step("alu");
        check("alu.data_const", 64'(o_rd_data), 64'h1234_5678);
        check("alu.we_const", 64'(o_rd_we), 64'd1);

        drive(1, 0, 1, 5'd7, 2'b01, 3'b000, 32'h0000_1000, 32'h80F0_7F81, 0, 0);
        step("lb0");
        check("lb0.const", 64'(o_rd_data), 64'hFFFF_FF81);
        drive(1, 0, 1, 5'd7, 2'b01, 3'b100, 32'h0000_1001, 32'h80F0_7F81, 0, 0);
        step("lbu1");
        check("lbu1.const", 64'(o_rd_data), 64'h0000_007F);
        drive(1, 0, 1, 5'd7, 2'b01, 3'b001, 32'h0000_1002, 32'h80F0_7F81, 0, 0);
        step("lh2");
        check("lh2.const", 64'(o_rd_data), 64'hFFFF_80F0);
        drive(1, 0, 1, 5'd7, 2'b01, 3'b101, 32'h0000_1000, 32'h80F0_7F81, 0, 0);
        step("lhu0");
        check("lhu0.const", 64'(o_rd_data), 64'h0000_7F81);
        drive(1, 0, 1, 5'd7, 2'b01, 3'b010, 32'h0000_1003, 32'h80F0_7F81, 0, 0);
        step("lw");
        check("lw.const", 64'(o_rd_data), 64'h80F0_7F81);

        drive(1, 0, 1, 5'd1, 2'b10, 3'b000, 0, 0, 32'h0000_0100, 0);
        step("jal");
        check("jal.const", 64'(o_rd_data), 64'h0000_0104);
        drive(1, 0, 1, 5'd1, 2'b10, 3'b000, 0, 0, 32'hFFFF_FFFC, 0);
        step("pc_wrap");
        check("pc_wrap.const", 64'(o_rd_data), 64'h0);
        drive(1, 0, 1, 5'd0, 2'b11, 3'b000, 0, 0, 0, 32'hDEAD_BEEF);
        step("csr_x0");
        check("csr_x0.data_const", 64'(o_rd_data), 64'hDEAD_BEEF);
        check("csr_x0.we_const", 64'(o_rd_we), 64'd0);
        check("csr_x0.retire_const", 64'(o_retire), 64'd1);

        drive(1, 1, 1, 5'd9, 2'b00, 3'b000, 32'h55, 0, 0, 0);
        step("flush");
        check("flush.we_const", 64'(o_rd_we), 64'd0);
        check("flush.retire_const", 64'(o_retire), 64'd0);
        step("flush2");

        // async reset mid-cycle discards the held instruction at once
        drive(1, 0, 1, 5'd3, 2'b00, 3'b000, 32'h77, 0, 0, 0);
        step("pre_async");
        #2;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 0, 0, 0);
            step("b2b");
        end
        drive(0, 0, 0, 5'd0, 2'b00, 3'b000, 0, 0, 0, 0);
        step("b2b_end");
        check("b2b.instret_const", o_instret, 64'd10);

        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        drive(1, 0, 1, 5'd2, 2'b00, 3'b000, 32'h9, 0, 0, 0);
        step("wrap0");
        step("wrap1");
        step("wrap2");
        check("wrap.instret_const", o_instret, 64'd0);

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
